// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
// State codes are one-hot per grant, so a state can never grant both requesters.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mux_arbiter_if.sv
// Requester-side bus of the mux arbiter: requests, releases, data in, and the
// grant/select/registered data returned by the arbiter.
interface mux_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;

  modport master (
    output req0, req1, done0, done1, d0, d1,
    input  gnt0, gnt1, sel, out, out_valid, busy
  );

  modport slave (
    input  req0, req1, done0, done1, d0, d1,
    output gnt0, gnt1, sel, out, out_valid, busy
  );
endinterface

// File: rtl/mux_arb_hold_cnt.sv
// Tenure counter: cleared when a grant starts, counts granted cycles and
// saturates at MAX_HOLD-1, where it flags that the holder may be preempted.
module mux_arb_hold_cnt #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  output logic [HOLD_W-1:0] cnt,
  output logic              expire
);
  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != LIMIT)) begin
      cnt_reg <= cnt_reg + HOLD_W'(1);
    end
  end

  assign cnt    = cnt_reg;
  assign expire = (cnt_reg == LIMIT);
endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner of a shared 2:1 mux select: grants one requester at a time,
// bounds contested tenure, and registers the muxed data.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input logic          clk,
  input logic          rst_n,
  mux_arbiter_if.slave bus
);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_t           state_reg, state_next;
  logic             last_reg, last_next;
  logic             sel_reg, sel_next;
  logic [WIDTH-1:0] out_reg;
  logic             out_valid_reg;
  logic [HOLD_W-1:0] hold_cnt;
  logic             hold_expire;
  logic             hold_clear;
  logic             hold_en;

  mux_arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (hold_clear),
    .enable (hold_en),
    .cnt    (hold_cnt),
    .expire (hold_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= REQ1;
      sel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      sel_reg   <= sel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    sel_next   = sel_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_next = (last_reg == REQ0) ? GRANT1 : GRANT0;
        end else if (bus.req0) begin
          state_next = GRANT0;
        end else if (bus.req1) begin
          state_next = GRANT1;
        end
      end
      GRANT0: begin
        if (bus.done0 || !bus.req0 || (hold_expire && bus.req1)) begin
          state_next = bus.req1 ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (bus.done1 || !bus.req1 || (hold_expire && bus.req0)) begin
          state_next = bus.req0 ? GRANT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Select and round-robin pointer move only when a new grant begins.
    if ((state_next == GRANT0) && (state_reg != GRANT0)) begin
      last_next = REQ0;
      sel_next  = REQ0;
    end else if ((state_next == GRANT1) && (state_reg != GRANT1)) begin
      last_next = REQ1;
      sel_next  = REQ1;
    end
  end

  assign hold_clear = (state_next != state_reg);
  assign hold_en    = (state_reg != IDLE);

  // Data lags the grant by one cycle; out freezes while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= (state_reg != IDLE);
      if (state_reg != IDLE) begin
        out_reg <= sel_reg ? bus.d1 : bus.d0;
      end
    end
  end

  assign bus.gnt0      = (state_reg == GRANT0);
  assign bus.gnt1      = (state_reg == GRANT1);
  assign bus.sel       = sel_reg;
  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios plus randomized
// traffic checked against a tenure-based behavioural model.
module tb_mux_arbiter;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux_arbiter_if #(.WIDTH(WIDTH)) bus ();
  mux_arbiter_if #(.WIDTH(WIDTH)) bus1 ();

  mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Second instance at the MAX_HOLD=1 boundary, fed the same requester inputs.
  mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  assign bus1.req0  = bus.req0;
  assign bus1.req1  = bus.req1;
  assign bus1.done0 = bus.done0;
  assign bus1.done1 = bus.done1;
  assign bus1.d0    = bus.d0;
  assign bus1.d1    = bus.d1;

  // Reference model: owner (-1 none), cycles held by current owner, last winner.
  int         m_owner;
  int         m_held;
  int         m_last;
  logic       m_sel;
  logic [7:0] m_out;
  logic       m_valid;

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 1;
    m_sel   = 1'b0;
    m_out   = '0;
    m_valid = 1'b0;
  endfunction

  function automatic void model_step(input logic r0, input logic r1, input logic dn0,
                                     input logic dn1, input logic [7:0] dd0,
                                     input logic [7:0] dd1);
    int  nxt;
    logic mine, other, dn;
    if (m_owner >= 0) m_out = m_sel ? dd1 : dd0;
    m_valid = (m_owner >= 0);
    nxt = m_owner;
    if (m_owner < 0) begin
      if (r0 && r1)  nxt = (m_last == 0) ? 1 : 0;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
    end else begin
      mine  = (m_owner == 0) ? r0 : r1;
      other = (m_owner == 0) ? r1 : r0;
      dn    = (m_owner == 0) ? dn0 : dn1;
      if (dn || !mine || (m_held >= MAX_HOLD && other))
        nxt = other ? 1 - m_owner : -1;
    end
    if (nxt < 0) begin
      m_held = 0;
    end else if (nxt != m_owner) begin
      m_last = nxt;
      m_sel  = (nxt == 1);
      m_held = 1;
    end else begin
      m_held = m_held + 1;
    end
    m_owner = nxt;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(bus.req0, bus.req1, bus.done0, bus.done1, bus.d0, bus.d1);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic r0, input logic r1);
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req0 = r0;
    bus.req1 = r1;
    bus.done0 = 1'b0;
    bus.done1 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.done0 = 1'b0; bus.done1 = 1'b0;
    bus.d0 = 8'h77; bus.d1 = 8'h88;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.sel, bus.out_valid, bus.busy, bus.out} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got gnt0=%b gnt1=%b sel=%b ov=%b busy=%b out=%h exp all 0",
               bus.gnt0, bus.gnt1, bus.sel, bus.out_valid, bus.busy, bus.out);
    end
    checks++;
    if (u_dut.hold_cnt !== '0) begin
      errors++;
      $display("FAIL reset_hold_cnt got=%0d exp=0", u_dut.hold_cnt);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_grant got gnt0=%b gnt1=%b exp gnt0=1 gnt1=0", bus.gnt0, bus.gnt1);
    end
    $display("txn test_reset done");
  endtask

  task automatic test_single();
    do_reset(1'b0, 1'b0);
    bus.req0 = 1'b1; bus.d0 = 8'hA5;
    tick();
    checks++;
    if ({bus.gnt0, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL single_edge1 got gnt0=%b ov=%b exp gnt0=1 ov=0", bus.gnt0, bus.out_valid);
    end
    for (int k = 2; k <= 3; k++) begin
      tick();
      checks++;
      if ({bus.gnt0, bus.out_valid, bus.out} !== {2'b11, 8'hA5}) begin
        errors++;
        $display("FAIL single_stream edge=%0d got gnt0=%b ov=%b out=%h exp 1 1 a5",
                 k, bus.gnt0, bus.out_valid, bus.out);
      end
    end
    bus.done0 = 1'b1; bus.req0 = 1'b0;
    tick();
    bus.done0 = 1'b0;
    checks++;
    if ({bus.gnt0, bus.busy, bus.out} !== {2'b00, 8'hA5}) begin
      errors++;
      $display("FAIL single_release got gnt0=%b busy=%b out=%h exp 0 0 a5", bus.gnt0, bus.busy, bus.out);
    end
    tick();
    checks++;
    if ({bus.busy, bus.out_valid, bus.out} !== {2'b00, 8'hA5}) begin
      errors++;
      $display("FAIL single_idle_hold got busy=%b ov=%b out=%h exp 0 0 a5",
               bus.busy, bus.out_valid, bus.out);
    end
    $display("txn test_single done");
  endtask

  task automatic test_handoff();
    do_reset(1'b1, 1'b1);
    bus.d0 = 8'h11; bus.d1 = 8'h3C;
    tick();
    tick();
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.sel} !== 3'b100) begin
      errors++;
      $display("FAIL handoff_grant0 got gnt0=%b gnt1=%b sel=%b exp 1 0 0", bus.gnt0, bus.gnt1, bus.sel);
    end
    bus.done0 = 1'b1;
    tick();
    bus.done0 = 1'b0;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.sel, bus.busy, bus.out} !== {4'b0111, 8'h11}) begin
      errors++;
      $display("FAIL handoff_transfer got gnt0=%b gnt1=%b sel=%b busy=%b out=%h exp 0 1 1 1 11",
               bus.gnt0, bus.gnt1, bus.sel, bus.busy, bus.out);
    end
    tick();
    checks++;
    if (bus.out !== 8'h3C) begin
      errors++;
      $display("FAIL handoff_data got out=%h exp 3c", bus.out);
    end
    $display("txn test_handoff done");
  endtask

  task automatic test_preempt();
    do_reset(1'b1, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      logic exp0;
      tick();
      exp0 = (((k - 1) / MAX_HOLD) % 2) == 0;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.sel} !== {exp0, ~exp0, ~exp0}) begin
        errors++;
        $display("FAIL preempt edge=%0d got gnt0=%b gnt1=%b sel=%b exp gnt0=%b",
                 k, bus.gnt0, bus.gnt1, bus.sel, exp0);
      end
    end
    $display("txn test_preempt done");
  endtask

  task automatic test_max_hold_one();
    do_reset(1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      logic exp0;
      tick();
      exp0 = (k % 2) == 1;
      checks++;
      if ({bus1.gnt0, bus1.gnt1} !== {exp0, ~exp0}) begin
        errors++;
        $display("FAIL hold1_alternate edge=%0d got gnt0=%b gnt1=%b exp gnt0=%b",
                 k, bus1.gnt0, bus1.gnt1, exp0);
      end
    end
    $display("txn test_max_hold_one done");
  endtask

  task automatic test_uncontested();
    do_reset(1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      int expc;
      tick();
      expc = (k - 1 < MAX_HOLD - 1) ? k - 1 : MAX_HOLD - 1;
      checks++;
      if ({bus.gnt1, bus.gnt0} !== 2'b10 || int'(u_dut.hold_cnt) != expc) begin
        errors++;
        $display("FAIL uncontested edge=%0d got gnt1=%b gnt0=%b hold_cnt=%0d exp 1 0 %0d",
                 k, bus.gnt1, bus.gnt0, u_dut.hold_cnt, expc);
      end
    end
    bus.req1 = 1'b0;
    tick();
    checks++;
    if ({bus.gnt1, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL uncontested_drop got gnt1=%b busy=%b exp 0 0", bus.gnt1, bus.busy);
    end
    $display("txn test_uncontested done");
  endtask

  task automatic test_async_reset();
    do_reset(1'b0, 1'b1);
    bus.d1 = 8'h5A;
    repeat (3) tick();
    checks++;
    if ({bus.gnt1, bus.sel, bus.out_valid} !== 3'b111) begin
      errors++;
      $display("FAIL async_pre got gnt1=%b sel=%b ov=%b exp 1 1 1", bus.gnt1, bus.sel, bus.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt1, bus.sel, bus.out_valid, bus.busy, bus.out} !== 12'h0) begin
      errors++;
      $display("FAIL async_reset got gnt1=%b sel=%b ov=%b busy=%b out=%h exp all 0",
               bus.gnt1, bus.sel, bus.out_valid, bus.busy, bus.out);
    end
    bus.req0 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL async_restart got gnt0=%b gnt1=%b exp 1 0", bus.gnt0, bus.gnt1);
    end
    $display("txn test_async_reset done");
  endtask

  task automatic test_random();
    int prev_owner;
    do_reset(1'b0, 1'b0);
    prev_owner = -1;
    for (int c = 0; c < 1500; c++) begin
      bus.req0  = ($urandom_range(0, 9) < 7);
      bus.req1  = ($urandom_range(0, 9) < 7);
      bus.done0 = ($urandom_range(0, 9) < 1);
      bus.done1 = ($urandom_range(0, 9) < 1);
      bus.d0    = 8'($urandom);
      bus.d1    = 8'($urandom);
      tick();
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.sel, bus.busy, bus.out_valid} !==
          {m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, m_valid}) begin
        errors++;
        $display("FAIL rnd_ctrl cycle=%0d got g0=%b g1=%b sel=%b busy=%b ov=%b exp owner=%0d sel=%b ov=%b",
                 c, bus.gnt0, bus.gnt1, bus.sel, bus.busy, bus.out_valid, m_owner, m_sel, m_valid);
      end
      checks++;
      if (bus.out !== m_out) begin
        errors++;
        $display("FAIL rnd_out cycle=%0d got=%h exp=%h", c, bus.out, m_out);
      end
      if (m_owner != prev_owner) begin
        $display("txn cycle=%0d grant=%0d", c, m_owner);
        prev_owner = m_owner;
      end
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.done0 = 1'b0; bus.done1 = 1'b0;
    bus.d0 = '0; bus.d1 = '0;
    model_reset();
    test_reset();
    test_single();
    test_handoff();
    test_preempt();
    test_max_hold_one();
    test_uncontested();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
